// File: rtl/fetch_stage_if.sv
// Instruction-memory read port shared between the fetch stage and the memory.
// The protocol is stateless per cycle: a read completes only in a cycle where
// imem_req and imem_ready are both high.
interface fetch_stage_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ready;

    // Fetch side drives the request and address.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    // Memory side returns the data and the ready strobe.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues reads to instruction memory, holds one
// delivered instruction for IF/ID, honours stall and redirect, and stops
// fetching after a HALT instruction until the next redirect.
module fetch_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          redirect,
    input  logic [15:0]   redirect_pc,
    fetch_stage_if.master imem,
    output logic [15:0]   pc_out,
    output logic [15:0]   inst_out,
    output logic          inst_valid,
    output logic          flush_out,
    output logic          halted
);

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e      state_q, state_d;
    logic [15:0] fetch_pc_q, fetch_pc_d;
    logic [15:0] inst_q, inst_d;
    logic [15:0] pc_out_q, pc_out_d;
    logic        inst_valid_q, inst_valid_d;

    logic        slot_free;
    logic        req;
    logic        accept;
    logic        is_halt;
    logic [15:0] pc_plus2;

    // Request generation and output decode. rst gates the request so no read
    // is issued while the block is held in reset.
    always_comb begin
        slot_free = ~inst_valid_q | ~stall;
        req       = ~rst & (state_q == StRun) & slot_free & ~redirect;
        accept    = req & imem.imem_ready;
        is_halt   = (imem.imem_rdata[15:12] == HALT_OPCODE);
        pc_plus2  = fetch_pc_q + 16'd2;
        flush_out = redirect | ~inst_valid_q;
        halted    = (state_q == StHalt);
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = fetch_pc_q;
    assign pc_out         = pc_out_q;
    assign inst_out       = inst_q;
    assign inst_valid     = inst_valid_q;

    // Next-state: redirect wins over everything, then accept, then consume.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        inst_d       = inst_q;
        pc_out_d     = pc_out_q;
        inst_valid_d = inst_valid_q;

        if (redirect) begin
            // Squash the held instruction and discard any same-cycle data.
            fetch_pc_d   = redirect_pc;
            inst_valid_d = 1'b0;
            state_d      = StRun;
        end else if (accept) begin
            inst_d       = imem.imem_rdata;
            pc_out_d     = pc_plus2;
            inst_valid_d = 1'b1;
            if (is_halt) begin
                // HALT is delivered but the PC stays on it.
                state_d = StHalt;
            end else begin
                fetch_pc_d = pc_plus2;
            end
        end else if (inst_valid_q && !stall) begin
            inst_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StRun;
            fetch_pc_q   <= RESET_PC;
            inst_q       <= 16'h0000;
            pc_out_q     <= 16'h0000;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            inst_q       <= inst_d;
            pc_out_q     <= pc_out_d;
            inst_valid_q <= inst_valid_d;
        end
    end

endmodule
